// File: rtl/clock_div_prog_pkg.sv
// Shared definitions for the programmable clock divider: divisor floor and the
// per-edge channel action encoding, listed from highest to lowest priority.
package clock_div_prog_pkg;

   localparam int MIN_DIV = 2;

   // Reset outranks all of these and is handled directly in the channel flops.
   typedef enum logic [1:0] {
      ACT_DISABLE = 2'd0,
      ACT_RESTART = 2'd1,
      ACT_WRAP    = 2'd2,
      ACT_COUNT   = 2'd3
   } ch_action_e;

   // Every action except a plain count lands on phase 0, which is where a
   // pending divisor may be swapped in without glitching the output.
   function automatic logic is_boundary(input ch_action_e act);
      return act != ACT_COUNT;
   endfunction

endpackage

// File: rtl/clock_div_channel.sv
// One divider channel: phase counter, active and pending divisor, registered
// divided clock, phase-0 tick, pending flag and rejected-load pulse.
module clock_div_channel
   import clock_div_prog_pkg::*;
#(
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_en,
   input  logic             i_sync,
   input  logic             i_load,
   input  logic [DIV_W-1:0] i_value,
   output logic             o_pend,
   output logic             o_err,
   output logic             o_clk_out,
   output logic             o_tick
);

   logic [DIV_W-1:0] r_cnt;
   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_pend_div;
   logic             r_pend;
   logic             r_run;
   logic             r_clk_out;
   logic             r_tick;
   logic             r_err;

   ch_action_e       w_action;
   logic             w_load_ok;
   logic             w_load_bad;
   logic             w_apply;
   logic [DIV_W-1:0] w_div_next;
   logic [DIV_W-1:0] w_cnt_next;
   logic [DIV_W:0]   w_hi;

   always_comb begin
      w_load_ok  = i_load && (i_value >= DIV_W'(MIN_DIV));
      w_load_bad = i_load && !w_load_ok;

      if (!i_en) begin
         w_action = ACT_DISABLE;
      end else if (i_sync || !r_run) begin
         w_action = ACT_RESTART;
      end else if (r_cnt == r_div - DIV_W'(1)) begin
         w_action = ACT_WRAP;
      end else begin
         w_action = ACT_COUNT;
      end

      // A load on this same edge only becomes pending; the value swapped in
      // here is the one that was already waiting.
      w_apply    = is_boundary(w_action) && r_pend;
      w_div_next = w_apply ? r_pend_div : r_div;
      w_cnt_next = (w_action == ACT_COUNT) ? r_cnt + DIV_W'(1) : '0;
      // One extra bit so D = 2^DIV_W-1 cannot overflow the ceil(D/2) sum.
      w_hi       = ({1'b0, w_div_next} + (DIV_W+1)'(1)) >> 1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt      <= '0;
         r_div      <= DIV_W'(DEFAULT_DIV);
         r_pend_div <= DIV_W'(DEFAULT_DIV);
         r_pend     <= 1'b0;
         r_run      <= 1'b0;
         r_clk_out  <= 1'b0;
         r_tick     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_cnt     <= w_cnt_next;
         r_div     <= w_div_next;
         r_run     <= i_en;
         r_err     <= w_load_bad;
         r_clk_out <= (w_action != ACT_DISABLE) && ({1'b0, w_cnt_next} < w_hi);
         r_tick    <= (w_action != ACT_DISABLE) && (w_cnt_next == '0);

         if (w_load_ok) begin
            r_pend_div <= i_value;
            r_pend     <= 1'b1;
         end else if (w_apply) begin
            r_pend     <= 1'b0;
         end
      end
   end

   assign o_pend    = r_pend;
   assign o_err     = r_err;
   assign o_clk_out = r_clk_out;
   assign o_tick    = r_tick;

endmodule

// File: rtl/clock_div_prog.sv
// N_CH-channel programmable clock divider; each channel runs independently and
// the top only slices the divisor bus and gathers the per-channel outputs.
module clock_div_prog
   import clock_div_prog_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_CH-1:0]       ch_en,
   input  logic                  sync,
   input  logic [N_CH-1:0]       div_load,
   input  logic [N_CH*DIV_W-1:0] div_value,
   output logic [N_CH-1:0]       div_pend,
   output logic [N_CH-1:0]       div_err,
   output logic [N_CH-1:0]       clk_out,
   output logic [N_CH-1:0]       tick
);

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_ch
         clock_div_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
         ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .i_en      (ch_en[gi]),
            .i_sync    (sync),
            .i_load    (div_load[gi]),
            .i_value   (div_value[gi*DIV_W +: DIV_W]),
            .o_pend    (div_pend[gi]),
            .o_err     (div_err[gi]),
            .o_clk_out (clk_out[gi]),
            .o_tick    (tick[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_clock_div_prog.sv
// Bench for clock_div_prog: directed scenarios with literal expectations plus a
// long random run, all outputs compared every cycle against a phase-based model.
module tb_clock_div_prog;

   localparam int N_CH    = 4;
   localparam int DIV_W   = 8;
   localparam int DEF_DIV = 2;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [N_CH-1:0]       ch_en;
   logic                  sync;
   logic [N_CH-1:0]       div_load;
   logic [N_CH*DIV_W-1:0] div_value;
   logic [N_CH-1:0]       div_pend;
   logic [N_CH-1:0]       div_err;
   logic [N_CH-1:0]       clk_out;
   logic [N_CH-1:0]       tick;

   always #5 clk = ~clk;

   clock_div_prog #(
      .N_CH        (N_CH),
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEF_DIV)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .ch_en     (ch_en),
      .sync      (sync),
      .div_load  (div_load),
      .div_value (div_value),
      .div_pend  (div_pend),
      .div_err   (div_err),
      .clk_out   (clk_out),
      .tick      (tick)
   );

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_on = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
   endtask

   // Reference model: a channel is a phase in [0, D) advanced modulo D.
   // Output high while 2*phase < D (i.e. phase < ceil(D/2)); tick at phase 0.
   // A pending divisor is adopted whenever the new phase is 0.
   int m_run  [N_CH];
   int m_ph   [N_CH];
   int m_d    [N_CH];
   int m_pend [N_CH];
   logic [N_CH-1:0] e_clk, e_tick, e_pend, e_err;

   always @(posedge clk) begin : model
      int v;
      for (int i = 0; i < N_CH; i++) begin
         v = int'(div_value[i*DIV_W +: DIV_W]);
         if (!reset) begin
            m_run[i] = 0; m_ph[i] = 0; m_d[i] = DEF_DIV; m_pend[i] = 0;
            e_err[i] = 1'b0;
         end else begin
            e_err[i] = div_load[i] && (v < 2);
            if (!ch_en[i]) begin
               m_run[i] = 0; m_ph[i] = 0;
            end else if (sync || m_run[i] == 0) begin
               m_run[i] = 1; m_ph[i] = 0;
            end else begin
               m_ph[i] = (m_ph[i] + 1) % m_d[i];
            end
            if (m_ph[i] == 0 && m_pend[i] != 0) begin
               m_d[i] = m_pend[i]; m_pend[i] = 0;
            end
            if (div_load[i] && v >= 2) m_pend[i] = v;
         end
         e_clk[i]  = (m_run[i] != 0) && (2 * m_ph[i] < m_d[i]);
         e_tick[i] = (m_run[i] != 0) && (m_ph[i] == 0);
         e_pend[i] = (m_pend[i] != 0);
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         check("model_clk_out",  32'(clk_out),  32'(e_clk));
         check("model_tick",     32'(tick),     32'(e_tick));
         check("model_div_pend", 32'(div_pend), 32'(e_pend));
         check("model_div_err",  32'(div_err),  32'(e_err));
      end
   end

   task automatic exp_ch0(input string nm, input logic c, input logic t);
      @(negedge clk);
      check(nm, {30'b0, clk_out[0], tick[0]}, {30'b0, c, t});
   endtask

   task automatic load_ch0(input int val);
      div_value[DIV_W-1:0] = DIV_W'(val);
      div_load = 4'b0001;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
      $fatal(1, "watchdog");
   end

   initial begin
      bit e;
      reset = 1'b0; ch_en = '0; sync = 1'b0; div_load = '0; div_value = '0;
      repeat (2) @(negedge clk);
      chk_on = 1'b1;
      $display("reset state");
      check("rst_clk_out",  32'(clk_out),  32'd0);
      check("rst_tick",     32'(tick),     32'd0);
      check("rst_div_pend", 32'(div_pend), 32'd0);

      $display("T1 enable ch0 with default divisor 2");
      reset = 1'b1; ch_en = 4'b0001;
      exp_ch0("t1_c0", 1, 1); exp_ch0("t1_c1", 0, 0);
      exp_ch0("t1_c2", 1, 1); exp_ch0("t1_c3", 0, 0);
      exp_ch0("t1_c4", 1, 1);

      $display("T2 load D=5 mid-period");
      load_ch0(5);
      exp_ch0("t2_pre", 0, 0);
      check("t2_pend_set", 32'(div_pend[0]), 32'd1);
      div_load = '0;
      exp_ch0("t2_p0", 1, 1);
      check("t2_pend_clr", 32'(div_pend[0]), 32'd0);
      exp_ch0("t2_p1", 1, 0); exp_ch0("t2_p2", 1, 0);
      exp_ch0("t2_p3", 0, 0); exp_ch0("t2_p4", 0, 0);
      exp_ch0("t2_p5", 1, 1);

      $display("T3 rejected loads of 1 and 0");
      load_ch0(1);
      exp_ch0("t3_p1", 1, 0);
      check("t3_err1", 32'(div_err[0]), 32'd1);
      div_load = '0;
      exp_ch0("t3_p2", 1, 0);
      check("t3_err1_off", 32'(div_err[0]), 32'd0);
      load_ch0(0);
      exp_ch0("t3_p3", 0, 0);
      check("t3_err0", 32'(div_err[0]), 32'd1);
      div_load = '0;
      exp_ch0("t3_p4", 0, 0);
      check("t3_err0_off", 32'(div_err[0]), 32'd0);
      check("t3_no_pend", 32'(div_pend[0]), 32'd0);
      exp_ch0("t3_p5", 1, 1);

      $display("T4 loads 7 then 4 inside one period");
      load_ch0(7);
      exp_ch0("t4_p1", 1, 0);
      load_ch0(4);
      exp_ch0("t4_p2", 1, 0);
      check("t4_pend", 32'(div_pend[0]), 32'd1);
      div_load = '0;
      exp_ch0("t4_p3", 0, 0); exp_ch0("t4_p4", 0, 0);
      exp_ch0("t4_n0", 1, 1); exp_ch0("t4_n1", 1, 0);
      exp_ch0("t4_n2", 0, 0); exp_ch0("t4_n3", 0, 0);
      exp_ch0("t4_n4", 1, 1);

      $display("T5 ch0=6 ch1=3 ch2=6 staggered enables, then sync");
      div_value = {8'd0, 8'd6, 8'd3, 8'd6};
      div_load  = 4'b0111;
      @(negedge clk); div_load = '0; ch_en = 4'b0011;
      @(negedge clk); ch_en = 4'b0111;
      repeat (3) @(negedge clk);
      sync = 1'b1;
      @(negedge clk);
      check("t5_sync_clk",  32'(clk_out[2:0]), 32'd7);
      check("t5_sync_tick", 32'(tick[2:0]),    32'd7);
      sync = 1'b0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         e = (k % 6) < 3;
         check("t5_align_clk",  {30'b0, clk_out[2], clk_out[0]}, {30'b0, e, e});
         e = (k % 6) == 0;
         check("t5_align_tick", {30'b0, tick[2], tick[0]}, {30'b0, e, e});
      end

      $display("T6 reset mid-period, then disable mid-high");
      reset = 1'b0;
      @(negedge clk);
      check("t6_rst_clk",  32'(clk_out),  32'd0);
      check("t6_rst_tick", 32'(tick),     32'd0);
      check("t6_rst_pend", 32'(div_pend), 32'd0);
      reset = 1'b1;
      exp_ch0("t6_start", 1, 1);
      load_ch0(6);
      exp_ch0("t6_def1", 0, 0);
      div_load = '0;
      exp_ch0("t6_d6_p0", 1, 1);
      exp_ch0("t6_d6_p1", 1, 0);
      ch_en[0] = 1'b0;
      exp_ch0("t6_off", 0, 0);
      ch_en[0] = 1'b1;
      exp_ch0("t6_re0", 1, 1); exp_ch0("t6_re1", 1, 0);
      exp_ch0("t6_re2", 1, 0); exp_ch0("t6_re3", 0, 0);

      $display("random phase: 3000 cycles");
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 499) != 0);
         sync  = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 19) == 0) ch_en[$urandom_range(0, N_CH-1)] ^= 1'b1;
         for (int i = 0; i < N_CH; i++) begin
            div_load[i] = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0)
               div_value[i*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 255));
            else
               div_value[i*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 9));
         end
      end
      reset = 1'b1; sync = 1'b0; div_load = '0;
      repeat (3) @(negedge clk);
      chk_on = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
